// File: rtl/stdlib_arb_pkg.sv
// Shared defaults and index helpers for the round-robin arbiter and its one-hot encoder.
package stdlib_arb_pkg;

    localparam int DEF_N = 4;
    localparam int DEF_W = 8;

    // Index width for n requesters; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    typedef logic [idx_w(DEF_N)-1:0] idx_t;

endpackage

// File: rtl/stdlib_rr_arbiter_if.sv
// Request/grant bundle between N requesters, the arbiter and one downstream consumer.
interface stdlib_rr_arbiter_if
    import stdlib_arb_pkg::*;
#(
    parameter int N = DEF_N,
    parameter int W = DEF_W
);

    localparam int IW = idx_w(N);

    logic [N-1:0]   io_in_valid;
    logic [N-1:0]   io_in_ready;
    logic [N*W-1:0] io_in_bits;
    logic [N-1:0]   io_in_last;
    logic           io_out_valid;
    logic           io_out_ready;
    logic [W-1:0]   io_out_bits;
    logic           io_out_last;
    logic [IW-1:0]  io_chosen;

    // Arbiter side: consumes requests, drives the arbitrated stream.
    modport master (
        input  io_in_valid, io_in_bits, io_in_last, io_out_ready,
        output io_in_ready, io_out_valid, io_out_bits, io_out_last, io_chosen
    );

    // Environment side: requesters plus downstream consumer.
    modport slave (
        output io_in_valid, io_in_bits, io_in_last, io_out_ready,
        input  io_in_ready, io_out_valid, io_out_bits, io_out_last, io_chosen
    );

endinterface

// File: rtl/stdlib_oh_to_uint.sv
// One-hot to binary index encoder built as a recursive OR-fold of halves; all-zero input gives 0.
module stdlib_oh_to_uint
    import stdlib_arb_pkg::*;
#(
    parameter int N = DEF_N
) (
    input  logic [N-1:0]          oh_i,
    output logic [idx_w(N)-1:0]   idx_o
);

    generate
        if (N <= 2) begin : g_leaf
            assign idx_o = oh_i[N-1];
        end else begin : g_fold
            localparam int H = N / 2;

            logic [H-1:0]           lo;
            logic [H-1:0]           hi;
            logic [H-1:0]           folded;
            logic [idx_w(H)-1:0]    sub_idx;

            assign lo     = oh_i[H-1:0];
            assign hi     = oh_i[N-1:H];
            // With a one-hot input, the MSB is "hit in upper half" and the rest is the
            // index of the hit within whichever half holds it.
            assign folded = lo | hi;

            stdlib_oh_to_uint #(
                .N (H)
            ) u_sub (
                .oh_i  (folded),
                .idx_o (sub_idx)
            );

            assign idx_o = {(|hi), sub_idx};
        end
    endgenerate

endmodule

// File: rtl/stdlib_rr_arbiter.sv
// Round-robin arbiter over N valid/ready requesters with a combinational grant path.
// Define STDLIB_RR_ARBITER_LOCK_EN to hold the grant on one requester until its last beat.
module stdlib_rr_arbiter
    import stdlib_arb_pkg::*;
#(
    parameter int N = DEF_N,
    parameter int W = DEF_W
) (
    input  logic                clk,
    input  logic                reset,
    stdlib_rr_arbiter_if.master io
);

    localparam int            IW      = idx_w(N);
    localparam logic [IW-1:0] PTR_RST = IW'(N - 1);

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;

    logic [N-1:0]  rr_grant;
    logic [N-1:0]  grant;
    logic [IW-1:0] cand;
    logic          found;
    logic [IW-1:0] chosen;
    logic          arb_valid;
    logic          out_valid;
    logic          fire;
    logic [W-1:0]  sel_bits;
    logic          sel_last;

    // Scan ptr+1, ptr+2, ... wrapping, ptr itself last; N is a power of two so the
    // IW-bit add wraps modulo N for free.
    always_comb begin
        rr_grant = '0;
        found    = 1'b0;
        cand     = '0;
        for (int k = 1; k <= N; k++) begin
            cand = ptr_q + IW'(k);
            if (!found && io.io_in_valid[cand]) begin
                rr_grant[cand] = 1'b1;
                found          = 1'b1;
            end
        end
    end

`ifdef STDLIB_RR_ARBITER_LOCK_EN
    logic          lock_q;
    logic          lock_d;
    logic [IW-1:0] lock_idx_q;
    logic [IW-1:0] lock_idx_d;

    always_comb begin
        grant     = rr_grant;
        arb_valid = |io.io_in_valid;
        if (lock_q) begin
            grant             = '0;
            grant[lock_idx_q] = 1'b1;
            arb_valid         = io.io_in_valid[lock_idx_q];
        end
    end

    always_comb begin
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        if (fire) begin
            if (sel_last) begin
                lock_d = 1'b0;
            end else begin
                lock_d     = 1'b1;
                lock_idx_d = chosen;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
        end
    end
`else
    always_comb begin
        grant     = rr_grant;
        arb_valid = |io.io_in_valid;
    end
`endif

    stdlib_oh_to_uint #(
        .N (N)
    ) u_oh_to_uint (
        .oh_i  (grant),
        .idx_o (chosen)
    );

    // AND-OR payload mux keyed directly by the one-hot grant.
    always_comb begin
        sel_bits = '0;
        sel_last = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                sel_bits = sel_bits | io.io_in_bits[i*W +: W];
                sel_last = sel_last | io.io_in_last[i];
            end
        end
    end

    // Handshakes are forced low while reset is held, independent of the clock.
    assign out_valid       = arb_valid & ~reset;
    assign fire            = out_valid & io.io_out_ready;

    assign io.io_out_valid = out_valid;
    assign io.io_in_ready  = reset ? '0 : (grant & {N{io.io_out_ready}});
    assign io.io_out_bits  = sel_bits;
    assign io.io_out_last  = sel_last;
    assign io.io_chosen    = chosen;

    always_comb begin
        ptr_d = ptr_q;
        if (fire) begin
            ptr_d = chosen;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= PTR_RST;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: doc/stdlib_rr_arbiter.md
STDLIB_RR_ARBITER -- requirements
Module: stdlib_rr_arbiter

Interface
REQ-001 Parameter N, default 4: number of requesters, power of two, 2..16.
REQ-002 Parameter W, default 8: payload width per requester.
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 io_in_valid  input  N  per-requester valid.
REQ-006 io_in_ready  output  N  per-requester ready.
REQ-007 io_in_bits  input  N*W  payloads; requester i occupies bits [i*W+W-1:i*W].
REQ-008 io_in_last  input  N  per-requester last-beat flag.
REQ-009 io_out_valid  output  1  arbitrated valid.
REQ-010 io_out_ready  input  1  downstream ready.
REQ-011 io_out_bits  output  W  granted payload.
REQ-012 io_out_last  output  1  granted last flag.
REQ-013 io_chosen  output  log2(N)  binary index of granted requester.

Function
REQ-014 Fire = io_out_valid && io_out_ready; a beat transfers only on fire.
REQ-015 Grant is one-hot: first valid requester scanning ptr+1, ptr+2, ... wrapping mod N, ptr last.
REQ-016 io_chosen is the binary encoding of the one-hot grant; all-zeros grant gives io_chosen = 0.
REQ-017 io_out_valid = OR of io_in_valid when unlocked; combinational, zero-cycle latency.
REQ-018 io_out_bits/io_out_last = granted requester's bits/last; don't-care when io_out_valid = 0.
REQ-019 io_in_ready[i] = io_out_ready && grant[i]; at most one ready bit high; ready never depends on io_out_valid.
REQ-020 On fire, ptr <= io_chosen next cycle; no fire leaves ptr unchanged.
REQ-021 Single requester valid repeatedly is granted every cycle (no idle bubble).
REQ-022 Grant may change between cycles while io_out_ready = 0 (no grant hold unless locked).

Reset
REQ-023 Reset asserted: ptr = N-1 (requester 0 highest priority after reset), lock = 0, lock_idx = 0.
REQ-024 While reset asserted: io_in_ready = 0, io_out_valid = 0, regardless of inputs.
REQ-025 Reset mid-burst aborts the lock immediately; first post-reset grant follows REQ-015 with ptr = N-1.

Configuration
REQ-026 Macro STDLIB_RR_ARBITER_LOCK_EN enables burst locking.
REQ-027 With macro: fire with io_out_last = 0 sets lock = 1, lock_idx = io_chosen.
REQ-028 With macro, while locked: grant forced to lock_idx; io_out_valid = io_in_valid[lock_idx]; others ready = 0 even if locked requester drops valid.
REQ-029 With macro: fire with io_out_last = 1 clears lock; ptr updates to lock_idx per REQ-020.
REQ-030 Without macro: no lock state; io_in_last passes through to io_out_last only; every beat re-arbitrated.

Structure
REQ-031 Package stdlib_arb_pkg holds N/W defaults, the idx width function (log2 N), and an idx_t typedef.
REQ-032 One sub-module, stdlib_oh_to_uint: N-bit one-hot in, log2(N)-bit index out, recursive OR-fold of halves; combinational.
REQ-033 ptr, lock, lock_idx are the only flops; all outputs otherwise combinational.

Verification (N=4, W=8)
REQ-034 Post-reset, valid=4'b1111, ready=1 for 4 cycles -> io_chosen 0,1,2,3; io_in_ready 0001,0010,0100,1000.
REQ-035 valid=4'b1010, io_out_ready=0 for 3 cycles then 1 -> chosen=1 throughout, ptr unchanged until fire; next cycle chosen=3.
REQ-036 Only requester 2 valid, bits=8'hA5, 5 cycles ready=1 -> 5 fires, io_out_bits=8'hA5, chosen=2 each cycle.
REQ-037 LOCK_EN: req1 sends 3 beats last=0,0,1 while req0/req2 valid -> chosen=1 for all 3 fires, then chosen=2; req1 valid drop mid-burst -> io_out_valid=0.
REQ-038 Reset asserted mid-burst (LOCK_EN) -> outputs 0 asynchronously; after release valid=4'b0011 -> chosen=0.
REQ-039 Macro undefined, same stimulus as REQ-037 -> grant rotates 1,2,0 beat-by-beat.
